// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared Q-format defaults, activation encodings and saturation helper
// Purpose: constants and the saturate-to-width function used by the PE accumulate pipeline.
// Ports: none (package).
package pe_pkg;

    // Q8.24 default format
    localparam int Q_WIDTH = 32;
    localparam int Q_FBITS = 24;

    // act_mode encodings
    localparam logic ACT_BYPASS = 1'b0;
    localparam logic ACT_PRELU  = 1'b1;

    // Widest value the saturation helper accepts; callers sign-extend into it.
    localparam int SAT_MAXW = 128;

    // Clamp a signed value to the signed range of a w-bit word. The result is
    // returned sign-extended to SAT_MAXW so callers can compare it against the
    // input to detect that clamping happened.
    function automatic logic signed [SAT_MAXW-1:0] sat_to_width(
        input logic signed [SAT_MAXW-1:0] x,
        input int                         w
    );
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        hi = (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
        lo = ~hi;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/pe_lane_tree.sv
// rtl/pe_lane_tree.sv - combinational N_LANE fixed-point multiply and balanced adder tree
// Purpose: forms one beat sum from packed activations and weights.
// Ports: a_i/w_i packed lanes (lane i at [i*WIDTH +: WIDTH]); sum_o ACC_W-bit signed beat sum.
module pe_lane_tree
    import pe_pkg::*;
#(
    parameter int WIDTH  = Q_WIDTH,
    parameter int FBITS  = Q_FBITS,
    parameter int N_LANE = 8,
    parameter int ACC_W  = WIDTH + 8
) (
    input  logic [N_LANE*WIDTH-1:0] a_i,
    input  logic [N_LANE*WIDTH-1:0] w_i,
    output logic signed [ACC_W-1:0] sum_o
);

    // Lane count padded to a power of two; padding leaves stay zero.
    localparam int NP = (N_LANE <= 1) ? 1 : (1 << $clog2(N_LANE));

    // Heap-ordered tree: node[1] is the root, leaves sit at node[NP..2*NP-1].
    logic signed [ACC_W-1:0]   node [1:2*NP-1];
    logic signed [WIDTH-1:0]   a_l;
    logic signed [WIDTH-1:0]   w_l;
    logic signed [2*WIDTH-1:0] prod;

    always_comb begin
        a_l  = '0;
        w_l  = '0;
        prod = '0;
        for (int i = 1; i < 2*NP; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < N_LANE; i++) begin
            a_l  = a_i[i*WIDTH +: WIDTH];
            w_l  = w_i[i*WIDTH +: WIDTH];
            prod = (2*WIDTH)'(a_l) * (2*WIDTH)'(w_l);
            // Arithmetic shift floors toward minus infinity; the cast then
            // sign-extends (or truncates) to the accumulator width.
            node[NP+i] = ACC_W'(prod >>> FBITS);
        end
        for (int i = NP - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
    end

    assign sum_o = node[1];

endmodule

// File: rtl/pe_acc_pipe.sv
// rtl/pe_acc_pipe.sv - 3-stage dot-product accumulate pipeline with bias, saturation and PReLU
// Purpose: accumulates multi-beat dot products and emits one activated result per s_last beat.
// Ports: clk/rst (sync, active-high); s_valid/s_ready/s_last/s_a/s_w/s_bias/s_alpha/act_mode input
//        beat; m_valid/m_ready/m_data result; sat_flag sticky saturation indicator.
module pe_acc_pipe
    import pe_pkg::*;
#(
    parameter int WIDTH  = Q_WIDTH,
    parameter int FBITS  = Q_FBITS,
    parameter int N_LANE = 8,
    parameter int ACC_W  = WIDTH + 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    input  logic [N_LANE*WIDTH-1:0] s_a,
    input  logic [N_LANE*WIDTH-1:0] s_w,
    input  logic [WIDTH-1:0]        s_bias,
    input  logic [WIDTH-1:0]        s_alpha,
    input  logic                    act_mode,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    sat_flag
);

    // Whole pipeline moves in lockstep; a stalled output freezes every stage.
    logic adv;
    logic accept;

    logic                    m_valid_q;
    logic [WIDTH-1:0]        m_data_q;
    logic                    sat_q;

    assign adv     = !m_valid_q || m_ready;
    assign s_ready = adv;
    assign accept  = s_valid && adv;

    assign m_valid  = m_valid_q;
    assign m_data   = m_data_q;
    assign sat_flag = sat_q;

    // S1: lane products reduced to a beat sum
    logic signed [ACC_W-1:0] beat_sum;

    pe_lane_tree #(
        .WIDTH  (WIDTH),
        .FBITS  (FBITS),
        .N_LANE (N_LANE),
        .ACC_W  (ACC_W)
    ) u_lane_tree (
        .a_i   (s_a),
        .w_i   (s_w),
        .sum_o (beat_sum)
    );

    logic                    first_q;
    logic                    s1_valid_q;
    logic                    s1_last_q;
    logic                    s1_first_q;
    logic signed [ACC_W-1:0] s1_sum_q;
    logic signed [WIDTH-1:0] s1_bias_q;
    logic signed [WIDTH-1:0] s1_alpha_q;
    logic                    s1_mode_q;

    // S2: accumulator
    logic                    s2_fire_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [WIDTH-1:0] s2_bias_q;
    logic signed [WIDTH-1:0] s2_alpha_q;
    logic                    s2_mode_q;

    // S3 combinational: bias, saturate, activation
    logic signed [ACC_W:0]         x_wide;
    logic signed [SAT_MAXW-1:0]    x_ext;
    logic signed [SAT_MAXW-1:0]    x_clamped;
    logic signed [WIDTH-1:0]       x_s;
    logic                          sat_hit;
    logic signed [2*WIDTH-1:0]     prelu_prod;
    logic signed [2*WIDTH-1:0]     prelu_shift;
    logic [WIDTH-1:0]              y;

    always_comb begin
        // One extra bit so acc + bias can not wrap before clamping.
        x_wide      = (ACC_W+1)'(acc_q) + (ACC_W+1)'(s2_bias_q);
        x_ext       = SAT_MAXW'(x_wide);
        x_clamped   = sat_to_width(x_ext, WIDTH);
        sat_hit     = (x_clamped != x_ext);
        x_s         = x_clamped[WIDTH-1:0];
        prelu_prod  = (2*WIDTH)'(s2_alpha_q) * (2*WIDTH)'(x_s);
        prelu_shift = prelu_prod >>> FBITS;
        if (s2_mode_q == ACT_PRELU && x_s[WIDTH-1]) begin
            y = prelu_shift[WIDTH-1:0];
        end else begin
            y = x_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q    <= 1'b1;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_first_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_bias_q  <= '0;
            s1_alpha_q <= '0;
            s1_mode_q  <= ACT_BYPASS;
            s2_fire_q  <= 1'b0;
            acc_q      <= '0;
            s2_bias_q  <= '0;
            s2_alpha_q <= '0;
            s2_mode_q  <= ACT_BYPASS;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            sat_q      <= 1'b0;
        end else if (adv) begin
            // S1
            s1_valid_q <= s_valid;
            s1_last_q  <= s_last;
            s1_first_q <= first_q;
            s1_sum_q   <= beat_sum;
            if (accept) begin
                first_q <= s_last;
            end
            if (accept && s_last) begin
                s1_bias_q  <= s_bias;
                s1_alpha_q <= s_alpha;
                s1_mode_q  <= act_mode;
            end

            // S2
            s2_fire_q <= s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                acc_q <= s1_first_q ? s1_sum_q : acc_q + s1_sum_q;
            end
            if (s1_valid_q && s1_last_q) begin
                s2_bias_q  <= s1_bias_q;
                s2_alpha_q <= s1_alpha_q;
                s2_mode_q  <= s1_mode_q;
            end

            // S3: acc_q still holds the finished sum here even if S2 is
            // loading the next product's first beat on this same edge.
            m_valid_q <= s2_fire_q;
            if (s2_fire_q) begin
                m_data_q <= y;
                sat_q    <= sat_q | sat_hit;
            end
        end
    end

endmodule
